dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: RISC-V data-memory responder with byte/half/word lane steering, load extension,
// sticky first-fault capture and access counters. Loads are combinational; stores commit at posedge.
module dmem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   input  logic [2:0]  size,
   output logic [31:0] rdata,
   output logic        fault,
   output logic [31:0] fault_addr,
   output logic [1:0]  fault_cause,
   output logic [31:0] ld_count,
   output logic [31:0] st_count
);

   localparam int unsigned AW    = $clog2(MEM_WORDS);
   localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_MISAL = 2'b01;
   localparam logic [1:0] CAUSE_OOR   = 2'b10;
   localparam logic [1:0] CAUSE_SIZE  = 2'b11;

   logic [31:0]   mem_q [MEM_WORDS];

   logic [31:0]   offset;
   logic [AW-1:0] widx;
   logic [1:0]    lane;
   logic          size_bad;
   logic          oor;
   logic          misal;
   logic          chk_fail;
   logic [1:0]    cause;
   logic [31:0]   rword;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   rdata_c;
   logic [3:0]    wstrb;
   logic [31:0]   wword;
   logic          store_ok;
   logic          load_ok;

   logic          fault_q, fault_d;
   logic [31:0]   fault_addr_q, fault_addr_d;
   logic [1:0]    fault_cause_q, fault_cause_d;
   logic [31:0]   ld_count_q, ld_count_d;
   logic [31:0]   st_count_q, st_count_d;

   // Decode and access checks; the unsigned subtraction makes addresses below BASE_ADDR wrap out of range.
   always_comb begin
      offset   = addr - BASE_ADDR;
      widx     = offset[AW+1:2];
      lane     = offset[1:0];
      size_bad = (size == 3'b011) || (size[2:1] == 2'b11);
      oor      = {1'b0, offset} >= LIMIT;
      misal    = ((size[1:0] == 2'b01) && lane[0]) ||
                 ((size[1:0] == 2'b10) && (lane != 2'b00));
      chk_fail = size_bad || oor || misal;
      if (size_bad)   cause = CAUSE_SIZE;
      else if (oor)   cause = CAUSE_OOR;
      else if (misal) cause = CAUSE_MISAL;
      else            cause = CAUSE_NONE;
      store_ok = we && !chk_fail;
      load_ok  = re && !we && !chk_fail;
   end

   assign rword = mem_q[widx];

   always_comb begin
      byte_sel = rword[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rword[31:16] : rword[15:0];
      rdata_c  = '0;
      case (size)
         3'b000:  rdata_c = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  rdata_c = {{16{half_sel[15]}}, half_sel};
         3'b010:  rdata_c = rword;
         3'b100:  rdata_c = {24'b0, byte_sel};
         3'b101:  rdata_c = {16'b0, half_sel};
         default: rdata_c = '0;
      endcase
      if (chk_fail) rdata_c = '0;
   end

   // Store data is replicated across lanes so the strobe alone picks the target bytes.
   always_comb begin
      wstrb = 4'b0000;
      wword = wdata;
      case (size[1:0])
         2'b00: begin
            wstrb = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
         end
         2'b01: begin
            wstrb = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         2'b10: wstrb = 4'b1111;
         default: wstrb = 4'b0000;
      endcase
   end

   // A store whose edge falls while reset is held low is dropped; contents survive reset.
   always_ff @(posedge clk) begin
      if (reset && store_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[widx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

   always_comb begin
      fault_d       = fault_q;
      fault_addr_d  = fault_addr_q;
      fault_cause_d = fault_cause_q;
      ld_count_d    = ld_count_q;
      st_count_d    = st_count_q;
      if ((we || re) && chk_fail && !fault_q) begin
         fault_d       = 1'b1;
         fault_addr_d  = addr;
         fault_cause_d = cause;
      end
      if (store_ok) st_count_d = st_count_q + 32'd1;
      if (load_ok)  ld_count_d = ld_count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q       <= 1'b0;
         fault_addr_q  <= '0;
         fault_cause_q <= CAUSE_NONE;
         ld_count_q    <= '0;
         st_count_q    <= '0;
      end else begin
         fault_q       <= fault_d;
         fault_addr_q  <= fault_addr_d;
         fault_cause_q <= fault_cause_d;
         ld_count_q    <= ld_count_d;
         st_count_q    <= st_count_d;
      end
   end

   assign rdata       = rdata_c;
   assign fault       = fault_q;
   assign fault_addr  = fault_addr_q;
   assign fault_cause = fault_cause_q;
   assign ld_count    = ld_count_q;
   assign st_count    = st_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-addressed reference memory, expected responses queued at issue time
// and compared by an independent monitor at each falling edge.
module tb_dmem_responder;

   localparam int unsigned MEM_WORDS = 1024;
   localparam logic [31:0] BASE      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [2:0]  size = 3'b010;
   logic [31:0] rdata;
   logic        fault;
   logic [31:0] fault_addr;
   logic [1:0]  fault_cause;
   logic [31:0] ld_count;
   logic [31:0] st_count;

   dmem_responder #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re), .size(size),
      .rdata(rdata), .fault(fault), .fault_addr(fault_addr), .fault_cause(fault_cause),
      .ld_count(ld_count), .st_count(st_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] id;
      logic [31:0] rdata;
      logic        fault;
      logic [31:0] faddr;
      logic [1:0]  cause;
      logic [31:0] ld;
      logic [31:0] st;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned txn_id = 0;

   // Reference state
   bit [7:0]    mem_m [4*MEM_WORDS];
   bit          m_fault = 0;
   logic [31:0] m_faddr = '0;
   logic [1:0]  m_cause = '0;
   int unsigned m_ld = 0;
   int unsigned m_st = 0;

   task automatic check(input string name, input logic [31:0] id, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (txn %0d): got %h expected %h", name, id, act, exp);
      end
   endtask

   // Reference behaviour: size names a byte count and signedness; data is assembled little-endian.
   function automatic void model_access(input logic [31:0] a, input logic [2:0] sz,
                                        output logic [31:0] rd, output logic [1:0] cause,
                                        output int nb, output int unsigned off);
      bit     sgn;
      longint v;
      off = a - BASE;
      case (sz)
         3'b000:  begin nb = 1; sgn = 1; end
         3'b001:  begin nb = 2; sgn = 1; end
         3'b010:  begin nb = 4; sgn = 0; end
         3'b100:  begin nb = 1; sgn = 0; end
         3'b101:  begin nb = 2; sgn = 0; end
         default: begin nb = 0; sgn = 0; end
      endcase
      if (nb == 0)                 cause = 2'b11;
      else if (off >= 4*MEM_WORDS) cause = 2'b10;
      else if (off % nb != 0)      cause = 2'b01;
      else                         cause = 2'b00;
      rd = '0;
      if (cause == 2'b00) begin
         v = 0;
         for (int i = 0; i < nb; i++) v |= longint'(mem_m[off+i]) << (8*i);
         if (sgn && v[8*nb-1]) v -= (longint'(1) << (8*nb));
         rd = v[31:0];
      end
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic r,
                        input logic [2:0] sz, input bit use_k = 0, input logic [31:0] k = '0);
      exp_t        e;
      logic [31:0] rd;
      logic [1:0]  cause;
      int          nb;
      int unsigned off;
      @(posedge clk);
      #2;
      addr = a; wdata = wd; we = w; re = r; size = sz;
      model_access(a, sz, rd, cause, nb, off);
      txn_id++;
      e.id = txn_id; e.rdata = use_k ? k : rd;
      e.fault = m_fault; e.faddr = m_faddr; e.cause = m_cause; e.ld = m_ld; e.st = m_st;
      sb_q.push_back(e);
      if ((w || r) && cause != 2'b00 && !m_fault) begin
         m_fault = 1; m_faddr = a; m_cause = cause;
      end
      if (w && cause == 2'b00) begin
         for (int i = 0; i < nb; i++) mem_m[off+i] = wd[8*i +: 8];
         m_st++;
      end else if (r && cause == 2'b00) begin
         m_ld++;
      end
   endtask

   task automatic wait_drain();
      @(posedge clk);
      #2;
      we = 0; re = 0;
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) check("drain_timeout", 0, sb_q.size(), 0);
   endtask

   task automatic check_regs_clear(input string name);
      check({name, "_fault"}, 0, {31'b0, fault}, 0);
      check({name, "_faddr"}, 0, fault_addr, 0);
      check({name, "_cause"}, 0, {30'b0, fault_cause}, 0);
      check({name, "_ld"}, 0, ld_count, 0);
      check({name, "_st"}, 0, st_count, 0);
   endtask

   // Asynchronous reset between edges, optionally during a store that must be dropped.
   task automatic do_reset(input bit with_store, input logic [31:0] a, input logic [31:0] d);
      wait_drain();
      @(posedge clk);
      #2;
      addr = a; wdata = d; size = 3'b010; we = with_store; re = 0;
      #1 reset = 0;
      m_fault = 0; m_faddr = '0; m_cause = '0; m_ld = 0; m_st = 0;
      #1 check_regs_clear("reset_async");
      @(posedge clk);
      #2;
      we = 0;
      reset = 1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rdata", e.id, rdata, e.rdata);
            check("fault", e.id, {31'b0, fault}, {31'b0, e.fault});
            check("fault_addr", e.id, fault_addr, e.faddr);
            check("fault_cause", e.id, {30'b0, fault_cause}, {30'b0, e.cause});
            check("ld_count", e.id, ld_count, e.ld);
            check("st_count", e.id, st_count, e.st);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] a;
      #1 reset = 0;
      #2 check_regs_clear("reset_init");
      #20;
      @(negedge clk) reset = 1;

      for (int i = 0; i < MEM_WORDS; i++) issue(BASE + 4*i, 32'h0, 1, 0, 3'b010);
      do_reset(0, BASE, '0);

      issue(BASE + 32'h10, 32'hDEADBEEF, 1, 0, 3'b010);
      issue(BASE + 32'h10, 32'h0, 0, 1, 3'b010, 1, 32'hDEADBEEF);
      issue(BASE + 32'h11, 32'h7F, 1, 0, 3'b000);
      issue(BASE + 32'h10, 32'h0, 0, 1, 3'b010, 1, 32'hDEAD7FEF);
      issue(BASE + 32'h13, 32'h0, 0, 1, 3'b000, 1, 32'hFFFFFFDE);
      issue(BASE + 32'h13, 32'h0, 0, 1, 3'b100, 1, 32'h000000DE);
      issue(BASE + 32'h12, 32'h0, 0, 1, 3'b001, 1, 32'hFFFFDEAD);
      issue(BASE + 32'h12, 32'h0, 0, 1, 3'b101, 1, 32'h0000DEAD);
      issue(BASE + 32'h22, 32'h12345678, 1, 0, 3'b010, 1, 32'h0);
      issue(BASE + 32'h20, 32'h0, 0, 1, 3'b010, 1, 32'h0);

      do_reset(0, BASE, '0);
      issue(BASE + 32'h1000, 32'h0, 0, 1, 3'b010, 1, 32'h0);
      issue(BASE + 32'h3, 32'h0, 0, 1, 3'b001, 1, 32'h0);
      issue(BASE + 32'h40, 32'hAAAA5555, 1, 0, 3'b010, 1, 32'h0);
      issue(BASE + 32'h40, 32'h0, 0, 1, 3'b010, 1, 32'hAAAA5555);

      issue(BASE + 32'h80, 32'h11112222, 1, 0, 3'b010);
      issue(BASE + 32'h84, 32'h55667788, 1, 0, 3'b010);
      do_reset(1, BASE + 32'h80, 32'h33334444);
      issue(BASE + 32'h80, 32'h0, 0, 1, 3'b010, 1, 32'h11112222);
      issue(BASE + 32'h84, 32'h0, 0, 1, 3'b010, 1, 32'h55667788);
      issue(BASE + 32'h10, 32'h0, 0, 1, 3'b010, 1, 32'hDEAD7FEF);

      for (int n = 0; n < 600; n++) begin
         if (n % 100 == 0)
            do_reset($urandom_range(0, 1), BASE + 4*$urandom_range(0, MEM_WORDS-1), $urandom);
         if ($urandom_range(0, 7) == 0) a = $urandom;
         else a = BASE + $urandom_range(0, 4*MEM_WORDS + 7);
         issue(a, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 7)));
      end

      issue(BASE, 32'h0, 0, 0, 3'b010);
      wait_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
